// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-ported synchronous word memory.
// The data port normally wins; a fetch port that keeps losing is boosted to
// priority until it gets served. Read data returns one cycle after the grant
// to whichever port owned the read, and each port holds its last read word.
module mem_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // fetch port (read only)
  input  logic              i_if_req,
  input  logic [31:0]       i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [31:0]       o_if_rdata,
  // data port
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [31:0]       i_dm_addr,
  input  logic [31:0]       i_dm_wdata,
  output logic              o_dm_gnt,
  output logic              o_dm_rvalid,
  output logic [31:0]       o_dm_rdata,
  output logic              o_dm_err,
  // memory side
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  typedef enum logic {
    ST_NORMAL   = 1'b0,  // data port has priority
    ST_IF_BOOST = 1'b1   // fetch port has priority
  } state_e;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  state_e      state_q, state_d;
  logic [2:0]  starve_q, starve_d;
  logic        rd_pend_q, rd_pend_d;   // a read was granted last cycle
  logic        rd_dm_q, rd_dm_d;       // owner of that read: 1 = data port
  logic        rd_zero_q, rd_zero_d;   // that read was invalid, return zero
  logic [31:0] if_rdata_q, dm_rdata_q; // last word delivered to each port

  logic        if_req, dm_req;
  logic        if_gnt, dm_gnt;
  logic        if_oor, dm_bad;
  logic [31:0] rd_data;
  logic        if_addr_unused;

  // Requests are masked while in reset so every combinational output is 0
  // the moment rst_n falls, not just after the next edge.
  assign if_req = i_if_req & rst_n;
  assign dm_req = i_dm_req & rst_n;

  // Address decode: fetches ignore the byte offset, data accesses trap on it.
  assign if_oor         = |i_if_addr[31:ADDR_W+2];
  assign dm_bad         = (|i_dm_addr[31:ADDR_W+2]) | (|i_dm_addr[1:0]);
  assign if_addr_unused = ^i_if_addr[1:0];

  // Arbitration: a lone requester always wins; on contention the state decides.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (if_req && dm_req) begin
      if (state_q == ST_IF_BOOST) if_gnt = 1'b1;
      else                        dm_gnt = 1'b1;
    end else begin
      if_gnt = if_req;
      dm_gnt = dm_req;
    end
  end

  assign o_if_gnt = if_gnt;
  assign o_dm_gnt = dm_gnt;

  // Starvation tracking and priority state: boost once the fetch port has lost
  // STARVE_MAX times in a row, drop back after the fetch is served.
  always_comb begin
    starve_d = 3'd0;
    state_d  = state_q;
    if (if_req && !if_gnt) begin
      starve_d = (starve_q == 3'd7) ? starve_q : starve_q + 3'd1;
    end
    case (state_q)
      ST_NORMAL:   if (starve_d >= STARVE_LIM) state_d = ST_IF_BOOST;
      ST_IF_BOOST: if (if_gnt)                 state_d = ST_NORMAL;
      default:                                 state_d = ST_NORMAL;
    endcase
  end

  // Memory command for the granted access and bookkeeping for its read return.
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_dm_err    = 1'b0;
    rd_pend_d   = 1'b0;
    rd_dm_d     = 1'b0;
    rd_zero_d   = 1'b0;
    if (if_gnt) begin
      rd_pend_d = 1'b1;
      rd_zero_d = if_oor;
      if (!if_oor) begin
        o_mem_en   = 1'b1;
        o_mem_addr = i_if_addr[ADDR_W+1:2];
      end
    end else if (dm_gnt) begin
      rd_pend_d = ~i_dm_we;
      rd_dm_d   = 1'b1;
      if (dm_bad) begin
        o_dm_err  = 1'b1;
        rd_zero_d = 1'b1;
      end else begin
        o_mem_en   = 1'b1;
        o_mem_we   = i_dm_we;
        o_mem_addr = i_dm_addr[ADDR_W+1:2];
        if (i_dm_we) o_mem_wdata = i_dm_wdata;
      end
    end
  end

  // Read return: the owner of last cycle's read sees memory data (or zero for
  // an invalid access); the other port keeps showing its previous word.
  assign rd_data     = rd_zero_q ? 32'd0 : i_mem_rdata;
  assign o_if_rvalid = rd_pend_q & ~rd_dm_q;
  assign o_dm_rvalid = rd_pend_q &  rd_dm_q;
  assign o_if_rdata  = o_if_rvalid ? rd_data : if_rdata_q;
  assign o_dm_rdata  = o_dm_rvalid ? rd_data : dm_rdata_q;

  // Priority state and starve counter.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the asynchronous reset clears state without waiting for a clock
    // edge; state updates use non-blocking assignments so all flops sample
    // the same pre-edge values regardless of block ordering.
    if (!rst_n) begin
      state_q  <= ST_NORMAL;
      starve_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Pending-read tracker; a read in flight at reset is simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q <= 1'b0;
      rd_dm_q   <= 1'b0;
      rd_zero_q <= 1'b0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_dm_q   <= rd_dm_d;
      rd_zero_q <= rd_zero_d;
    end
  end

  // Per-port read data holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (o_if_rvalid) if_rdata_q <= rd_data;
      if (o_dm_rvalid) dm_rdata_q <= rd_data;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 12;
  localparam int STARVE_MAX = 4;
  localparam int DEPTH      = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_if_req = 1'b0;
  logic [31:0]       i_if_addr = '0;
  logic              o_if_gnt, o_if_rvalid;
  logic [31:0]       o_if_rdata;
  logic              i_dm_req = 1'b0, i_dm_we = 1'b0;
  logic [31:0]       i_dm_addr = '0, i_dm_wdata = '0;
  logic              o_dm_gnt, o_dm_rvalid, o_dm_err;
  logic [31:0]       o_dm_rdata;
  logic              o_mem_en, o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic [31:0]       i_mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr), .i_dm_wdata(i_dm_wdata),
    .o_dm_gnt(o_dm_gnt), .o_dm_rvalid(o_dm_rvalid), .o_dm_rdata(o_dm_rdata), .o_dm_err(o_dm_err),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  function automatic logic [31:0] init_word(int i);
    return (i == 4) ? 32'hDEADBEEF : ((32'(i) * 32'h9E3779B1) ^ 32'hA5A50F0F);
  endfunction

  // Synchronous memory the arbiter drives: one-cycle read latency.
  logic [31:0] mem [DEPTH];
  bit          env_init = 1'b0;
  always @(posedge clk) begin
    if (!env_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
      env_init <= 1'b1;
    end else if (o_mem_en) begin
      if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
      else          i_mem_rdata     <= mem[o_mem_addr];
    end
  end

  // Reference model state: memory contents, fetch losing streak, whether the
  // fetch port is owed priority, and the read due to return next cycle.
  logic [31:0] ref_mem [DEPTH];
  int          losses;
  bit          boost;
  bit          exp_pend, exp_pend_dm;
  logic [31:0] exp_rd_data, exp_if_rdata, exp_dm_rdata;
  bit          last_if_gnt, last_dm_gnt;
  int          checks = 0;
  int          errors = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(logic [31:0] a);
    return (a >> (ADDR_W + 2)) == 32'd0;
  endfunction

  function automatic logic [31:0] word_of(logic [31:0] a);
    return 32'(a[ADDR_W+1:2]);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 63)) << 2;
    else                           a = 32'($urandom_range(0, DEPTH - 1)) << 2;
    if ($urandom_range(0, 7) == 0)  a[1:0] = 2'($urandom_range(1, 3));
    if ($urandom_range(0, 11) == 0) a[$urandom_range(ADDR_W + 2, 31)] = 1'b1;
    return a;
  endfunction

  task automatic model_reset();
    losses       = 0;
    boost        = 1'b0;
    exp_pend     = 1'b0;
    exp_pend_dm  = 1'b0;
    exp_rd_data  = '0;
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
    last_if_gnt  = 1'b0;
    last_dm_gnt  = 1'b0;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_ctrl"}, 32'({o_if_gnt, o_if_rvalid, o_dm_gnt, o_dm_rvalid,
                               o_dm_err, o_mem_en, o_mem_we}), 32'd0);
    check({tag, "_addr"}, 32'(o_mem_addr), 32'd0);
    check({tag, "_wdata"}, o_mem_wdata, 32'd0);
    check({tag, "_if_rdata"}, o_if_rdata, 32'd0);
    check({tag, "_dm_rdata"}, o_dm_rdata, 32'd0);
  endtask

  // Sample mid-cycle, compare every output with the model, then advance the
  // model by one transaction-level step.
  task automatic eval();
    bit          e_if_gnt, e_dm_gnt, e_en, e_we, e_err, e_if_rv, e_dm_rv, if_ok, dm_ok;
    logic [31:0] e_addr, rd_word;
    @(negedge clk);
    e_if_rv = exp_pend && !exp_pend_dm;
    e_dm_rv = exp_pend && exp_pend_dm;
    if (e_if_rv) exp_if_rdata = exp_rd_data;
    if (e_dm_rv) exp_dm_rdata = exp_rd_data;
    if (i_if_req && i_dm_req) begin
      e_if_gnt = boost;
      e_dm_gnt = !boost;
    end else begin
      e_if_gnt = i_if_req;
      e_dm_gnt = i_dm_req;
    end
    if_ok  = in_range(i_if_addr);
    dm_ok  = in_range(i_dm_addr) && (i_dm_addr[1:0] == 2'b00);
    e_en   = (e_if_gnt && if_ok) || (e_dm_gnt && dm_ok);
    e_we   = e_dm_gnt && dm_ok && i_dm_we;
    e_err  = e_dm_gnt && !dm_ok;
    e_addr = e_if_gnt ? word_of(i_if_addr) : word_of(i_dm_addr);
    check("if_gnt", 32'(o_if_gnt), 32'(e_if_gnt));
    check("dm_gnt", 32'(o_dm_gnt), 32'(e_dm_gnt));
    check("mem_en", 32'(o_mem_en), 32'(e_en));
    check("mem_we", 32'(o_mem_we), 32'(e_we));
    check("dm_err", 32'(o_dm_err), 32'(e_err));
    if (e_en) check("mem_addr", 32'(o_mem_addr), e_addr);
    if (e_we) check("mem_wdata", o_mem_wdata, i_dm_wdata);
    check("if_rvalid", 32'(o_if_rvalid), 32'(e_if_rv));
    check("dm_rvalid", 32'(o_dm_rvalid), 32'(e_dm_rv));
    check("if_rdata", o_if_rdata, exp_if_rdata);
    check("dm_rdata", o_dm_rdata, exp_dm_rdata);
    rd_word = '0;
    if (e_if_gnt && if_ok)                rd_word = ref_mem[word_of(i_if_addr)];
    if (e_dm_gnt && dm_ok && !i_dm_we)    rd_word = ref_mem[word_of(i_dm_addr)];
    exp_pend    = e_if_gnt || (e_dm_gnt && !i_dm_we);
    exp_pend_dm = e_dm_gnt;
    exp_rd_data = rd_word;
    if (e_we) ref_mem[word_of(i_dm_addr)] = i_dm_wdata;
    if (e_if_gnt) begin
      losses = 0;
      boost  = 1'b0;
    end else if (i_if_req) begin
      losses++;
      if (losses >= STARVE_MAX) boost = 1'b1;
    end else begin
      losses = 0;
    end
    last_if_gnt = e_if_gnt;
    last_dm_gnt = e_dm_gnt;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    model_reset();

    // Reset holds every output low even with both ports requesting.
    i_if_req = 1'b1; i_if_addr = 32'h10;
    i_dm_req = 1'b1; i_dm_we = 1'b1; i_dm_addr = 32'h20; i_dm_wdata = 32'h1;
    repeat (3) adv();
    check_all_zero("reset");
    i_if_req = 1'b0; i_dm_req = 1'b0;
    rst_n = 1'b1;

    // Lone fetch of word 4: granted at once, data one cycle later.
    i_if_req = 1'b1; i_if_addr = 32'h10;
    eval();
    check("d1_if_gnt", 32'(o_if_gnt), 32'd1);
    check("d1_mem_addr", 32'(o_mem_addr), 32'd4);
    adv();
    i_if_req = 1'b0;
    eval();
    check("d1_if_rvalid", 32'(o_if_rvalid), 32'd1);
    check("d1_if_rdata", o_if_rdata, 32'hDEADBEEF);
    adv();

    // Contention: data write wins, fetch follows the next cycle.
    i_if_req = 1'b1; i_if_addr = 32'h0;
    i_dm_req = 1'b1; i_dm_we = 1'b1; i_dm_addr = 32'h20; i_dm_wdata = 32'h12345678;
    eval();
    check("d2_dm_gnt", 32'(o_dm_gnt), 32'd1);
    check("d2_mem_we", 32'(o_mem_we), 32'd1);
    check("d2_mem_addr", 32'(o_mem_addr), 32'd8);
    adv();
    i_dm_req = 1'b0;
    eval();
    check("d2_if_gnt", 32'(o_if_gnt), 32'd1);
    adv();
    i_if_req = 1'b0;
    eval();
    adv();

    // Starvation: fetch loses STARVE_MAX times, wins the next, then data again.
    i_if_req = 1'b1; i_if_addr = 32'h40;
    i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 32'h20;
    for (int k = 0; k < STARVE_MAX; k++) begin
      eval();
      check("d3_if_loses", 32'(o_if_gnt), 32'd0);
      adv();
    end
    eval();
    check("d3_if_boosted", 32'(o_if_gnt), 32'd1);
    adv();
    eval();
    check("d3_dm_again", 32'(o_dm_gnt), 32'd1);
    adv();
    i_if_req = 1'b0; i_dm_req = 1'b0;
    eval();
    adv();

    // Misaligned fetch reads the enclosing word; out-of-range fetch returns 0.
    i_if_req = 1'b1; i_if_addr = 32'h13;
    eval();
    check("d4_mis_addr", 32'(o_mem_addr), 32'd4);
    adv();
    i_if_addr = 32'h0000_4000;
    eval();
    check("d4_mis_rdata", o_if_rdata, 32'hDEADBEEF);
    check("d4_oor_en", 32'(o_mem_en), 32'd0);
    adv();
    i_if_req = 1'b0;
    eval();
    check("d4_oor_rdata", o_if_rdata, 32'd0);
    adv();

    // Invalid data accesses: error pulse, no memory access, zero read data.
    i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 32'h3;
    eval();
    check("d5_err_rd", 32'(o_dm_err), 32'd1);
    check("d5_en_rd", 32'(o_mem_en), 32'd0);
    adv();
    i_dm_we = 1'b1; i_dm_addr = 32'h0000_4000; i_dm_wdata = 32'hCAFEF00D;
    eval();
    check("d5_rvalid", 32'(o_dm_rvalid), 32'd1);
    check("d5_rdata", o_dm_rdata, 32'd0);
    check("d5_err_wr", 32'(o_dm_err), 32'd1);
    check("d5_en_wr", 32'(o_mem_en), 32'd0);
    adv();
    i_dm_req = 1'b0;
    eval();
    check("d5_no_rvalid", 32'(o_dm_rvalid), 32'd0);
    adv();

    // Reset during a granted read: outputs drop at once, read is discarded.
    i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 32'h10;
    eval();
    #1 rst_n = 1'b0;
    #1 check_all_zero("d6_async");
    model_reset();
    adv();
    rst_n = 1'b1; i_dm_req = 1'b0;
    eval();
    check("d6_no_rvalid", 32'(o_dm_rvalid), 32'd0);
    adv();
    eval();
    adv();

    // Randomized traffic; requests stay stable until the model grants them.
    for (int n = 0; n < 800; n++) begin
      if (!i_if_req || last_if_gnt) begin
        i_if_req  = ($urandom_range(0, 2) != 0);
        i_if_addr = rand_addr();
      end
      if (!i_dm_req || last_dm_gnt) begin
        i_dm_req   = ($urandom_range(0, 4) != 0);
        i_dm_we    = 1'($urandom_range(0, 1));
        i_dm_addr  = rand_addr();
        i_dm_wdata = $urandom();
      end
      eval();
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
